// File: rtl/udp_output_monitor.sv
// Output monitor for the UDP combinational stage: saturating f rising-edge count,
// e run-length detector, and (with UDP_MON_CHECK_EN) a sticky f == e&d consistency check.
module udp_output_monitor #(
    parameter int CNT_W   = 8,
    parameter int RUN_LEN = 4,
    parameter int RUN_W   = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             e_in,
    input  logic             f_in,
    input  logic             clear,
    output logic [CNT_W-1:0] f_count,
    output logic             f_ovf,
    output logic [RUN_W-1:0] run_len_cur,
    output logic             run_detect
`ifdef UDP_MON_CHECK_EN
    ,
    input  logic             d_in,
    output logic             chk_err
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HIT  = 2'b10
    } state_t;

    localparam logic [RUN_W-1:0] RUN_ONE    = RUN_W'(1);
    localparam logic [RUN_W-1:0] RUN_TARGET = RUN_W'(RUN_LEN);
    localparam logic [RUN_W-1:0] RUN_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] f_count_q, f_count_d;
    logic             f_ovf_q, f_ovf_d;
    logic             f_prev_q, f_prev_d;
    logic [RUN_W-1:0] run_len_q, run_len_d;
    logic             run_detect_q, run_detect_d;
    logic             f_rise;

    assign f_rise = in_valid & f_in & ~f_prev_q;

    always_comb begin
        f_prev_d     = f_prev_q;
        f_count_d    = f_count_q;
        f_ovf_d      = f_ovf_q;
        state_d      = state_q;
        run_len_d    = run_len_q;
        run_detect_d = 1'b0;

        if (in_valid) f_prev_d = f_in;

        // clear takes priority so a coincident edge is dropped, not counted
        if (clear) begin
            f_count_d = '0;
            f_ovf_d   = 1'b0;
        end else if (f_rise) begin
            if (f_count_q != CNT_MAX) f_count_d = f_count_q + CNT_ONE;
            else                      f_ovf_d   = 1'b1;
        end

        case (state_q)
            IDLE: if (in_valid) begin
                if (e_in) begin
                    run_len_d = RUN_ONE;
                    if (RUN_ONE == RUN_TARGET) begin
                        state_d      = HIT;
                        run_detect_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    run_len_d = '0;
                end
            end
            RUN: if (in_valid) begin
                if (e_in) begin
                    run_len_d = run_len_q + RUN_ONE;
                    if (run_len_q + RUN_ONE == RUN_TARGET) begin
                        state_d      = HIT;
                        run_detect_d = 1'b1;
                    end
                end else begin
                    state_d   = IDLE;
                    run_len_d = '0;
                end
            end
            HIT: if (in_valid) begin
                if (e_in) begin
                    if (run_len_q != RUN_MAX) run_len_d = run_len_q + RUN_ONE;
                end else begin
                    state_d   = IDLE;
                    run_len_d = '0;
                end
            end
            default: begin
                state_d   = IDLE;
                run_len_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            f_count_q    <= '0;
            f_ovf_q      <= 1'b0;
            f_prev_q     <= 1'b0;
            run_len_q    <= '0;
            run_detect_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            f_count_q    <= f_count_d;
            f_ovf_q      <= f_ovf_d;
            f_prev_q     <= f_prev_d;
            run_len_q    <= run_len_d;
            run_detect_q <= run_detect_d;
        end
    end

    assign f_count     = f_count_q;
    assign f_ovf       = f_ovf_q;
    assign run_len_cur = run_len_q;
    assign run_detect  = run_detect_q;

`ifdef UDP_MON_CHECK_EN
    logic chk_err_q, chk_err_d;

    always_comb begin
        chk_err_d = chk_err_q;
        if (in_valid && (f_in != (e_in & d_in))) chk_err_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) chk_err_q <= 1'b0;
        else       chk_err_q <= chk_err_d;
    end

    assign chk_err = chk_err_q;
`endif

endmodule

// File: tb/tb_udp_output_monitor.sv
// Directed bench for udp_output_monitor: default-parameter instance plus a CNT_W=2
// instance sharing the same stimulus for the saturation case.
module tb_udp_output_monitor;

    logic       clock = 1'b0;
    logic       reset, in_valid, e_in, f_in, clear, d_in;
    logic [7:0] f_count;
    logic [1:0] f_count2;
    logic       f_ovf, f_ovf2, run_detect, run_detect2;
    logic [3:0] run_len_cur, run_len_cur2;
    logic       chk_err, chk_err2;
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clock = ~clock;

    udp_output_monitor #(.CNT_W(8), .RUN_LEN(4), .RUN_W(4)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .e_in(e_in), .f_in(f_in),
        .clear(clear), .f_count(f_count), .f_ovf(f_ovf), .run_len_cur(run_len_cur),
        .run_detect(run_detect)
`ifdef UDP_MON_CHECK_EN
        , .d_in(d_in), .chk_err(chk_err)
`endif
    );

    udp_output_monitor #(.CNT_W(2), .RUN_LEN(4), .RUN_W(4)) dut2 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .e_in(e_in), .f_in(f_in),
        .clear(clear), .f_count(f_count2), .f_ovf(f_ovf2), .run_len_cur(run_len_cur2),
        .run_detect(run_detect2)
`ifdef UDP_MON_CHECK_EN
        , .d_in(d_in), .chk_err(chk_err2)
`endif
    );

`ifndef UDP_MON_CHECK_EN
    assign chk_err  = 1'b0;
    assign chk_err2 = 1'b0;
`endif

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // drive one cycle of inputs, then sample just after the capturing edge
    task automatic cyc(input logic v, input logic e, input logic f,
                       input logic clr = 1'b0, input logic rst = 1'b0, input logic d = 1'b1);
        reset = rst; in_valid = v; e_in = e; f_in = f; clear = clr; d_in = d;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; e_in = 1'b0; f_in = 1'b0; clear = 1'b0; d_in = 1'b0;
        @(posedge clock);
        #1;

        // 1: reset with random inputs, then idle with in_valid=0
        for (int i = 0; i < 2; i++)
            cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'($urandom));
        chk("rst_f_count", f_count, 0);
        chk("rst_f_ovf", f_ovf, 0);
        chk("rst_run_len", run_len_cur, 0);
        chk("rst_run_detect", run_detect, 0);
        chk("rst_chk_err", chk_err, 0);
        chk("rst_f_count2", f_count2, 0);
        for (int i = 0; i < 2; i++) cyc(1'b0, 1'($urandom), 1'($urandom));
        chk("idle_f_count", f_count, 0);
        chk("idle_run_len", run_len_cur, 0);
        chk("idle_run_detect", run_detect, 0);

        // 2: f = 0,1,1,0,1,0,1 with invalid gaps carrying noise
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        chk("edge_first", f_count, 1);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        chk("edge_second", f_count, 2);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        chk("edge_seq_count", f_count, 3);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("edge_gap_hold", f_count, 3);
        chk("edge_gap_ovf", f_ovf, 0);

        // clear while invalid; f_prev remains 1
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("clear_f_count", f_count, 0);
        chk("clear_f_count2", f_count2, 0);

        // 3: five edges; CNT_W=2 instance saturates at 3 and flags overflow
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            cyc(1'b1, 1'b0, 1'b1);
        end
        chk("sat_f_count8", f_count, 5);
        chk("sat_f_count2", f_count2, 3);
        chk("sat_f_ovf2", f_ovf2, 1);
        chk("sat_f_ovf8", f_ovf, 0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        chk("clr_edge_count2", f_count2, 0);
        chk("clr_edge_ovf2", f_ovf2, 0);
        chk("clr_edge_count8", f_count, 0);
        cyc(1'b1, 1'b0, 1'b1);
        chk("no_edge_after_clr", f_count, 0);

        // 4: e run of six with an invalid gap after the 2nd sample
        for (int i = 1; i <= 6; i++) begin
            cyc(1'b1, 1'b1, 1'b0);
            chk($sformatf("run4_len_%0d", i), run_len_cur, i);
            chk($sformatf("run4_det_%0d", i), run_detect, (i == 4) ? 1 : 0);
            if (i == 2) begin
                cyc(1'b0, 1'b0, 1'b0);
                chk("run4_gap_len", run_len_cur, 2);
                chk("run4_gap_det", run_detect, 0);
            end
        end
        cyc(1'b1, 1'b0, 1'b0);
        chk("run4_fall_len", run_len_cur, 0);
        chk("run4_fall_det", run_detect, 0);

        // 5: broken run then a complete one, then a run cut by reset
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, (i == 3) ? 1'b0 : 1'b1, 1'b0);
            chk($sformatf("run5_det_%0d", i + 1), run_detect, (i == 7) ? 1 : 0);
        end
        chk("run5_len", run_len_cur, 4);
        cyc(1'b1, 1'b1, 1'b0);
        chk("run5_hit_nopulse", run_detect, 0);
        chk("run5_hit_len", run_len_cur, 5);
        cyc(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("run5_rst_len", run_len_cur, 0);
        chk("run5_rst_det", run_detect, 0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("run5_fresh_len", run_len_cur, 1);
        chk("run5_fresh_det", run_detect, 0);

`ifdef UDP_MON_CHECK_EN
        // 6: consistency check of f against e&d
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("chk_ok", chk_err, 0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("chk_bad", chk_err, 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("chk_sticky_clear", chk_err, 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("chk_reset", chk_err, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
